// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg
// Shared constants for the destination-register scoreboard: register
// address width, register count, per-register counter width and limits.
package reg_scoreboard_pkg;

  localparam int ADDR_W  = 5;
  localparam int NREG    = 2 ** ADDR_W;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (2 ** CNT_W) - 1;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/sb_counter.sv
// sb_counter
// Outstanding-write counter for one architectural register.
// Ports:
//   clk, rst_n  : pipeline clock, asynchronous active-low reset
//   inc         : an accepted issue targets this register
//   dec         : write-back retires a write to this register
//   cnt         : current number of outstanding writes
//   busy        : cnt is non-zero
//   underflow   : pulse, a retire arrived while nothing was outstanding
module sb_counter
  import reg_scoreboard_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CNT_MAX);

  // Simultaneous inc and dec cancel out, so only one-sided changes move
  // the counter. Both ends saturate; the empty end reports underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && !dec && (cnt != LIMIT)) begin
      cnt <= cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign busy      = (cnt != '0);
  assign underflow = dec && !inc && (cnt == '0);

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Destination-register scoreboard between decode/issue and write-back.
// Ports:
//   clk, rst_n                    : pipeline clock, async active-low reset
//   issue_valid                   : decode presents an instruction
//   issue_dst, issue_wr           : destination address and write enable
//   issue_rs/rt, issue_uses_rs/rt : source addresses and read enables
//   issue_ready                   : combinational, instruction may issue
//   wb_valid, wb_dst              : write-back retiring a register write
//   busy_vec                      : bit i set while register i has writes pending
//   err                           : sticky write-back underflow flag
module reg_scoreboard
  import reg_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic              issue_wr,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic              issue_uses_rs,
  input  logic              issue_uses_rt,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dst,
  output logic [NREG-1:0]   busy_vec,
  output logic              err
);

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:1]            busyBits;
  logic [NREG-1:1]            underflowBits;
  logic                       rsHazard;
  logic                       rtHazard;
  logic                       dstFull;
  logic                       incEn;

  // Register 0 is hardwired, so it never holds a pending write.
  assign cnt[0] = '0;

  // Ready looks only at the issue inputs and the current counters; a
  // write-back in this cycle is not bypassed, it frees the source next cycle.
  always_comb begin
    rsHazard    = issue_uses_rs && (issue_rs != REG_ZERO) && (cnt[issue_rs] != '0);
    rtHazard    = issue_uses_rt && (issue_rt != REG_ZERO) && (cnt[issue_rt] != '0);
    dstFull     = issue_wr && (issue_dst != REG_ZERO) &&
                  (cnt[issue_dst] == CNT_W'(CNT_MAX));
    issue_ready = !(rsHazard || rtHazard || dstFull);
  end

  assign incEn = issue_valid && issue_ready && issue_wr;

  // One counter per writable register; the address compare inside the loop
  // forms the one-hot decode of issue_dst and wb_dst.
  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (incEn && (issue_dst == ADDR_W'(i))),
      .dec       (wb_valid && (wb_dst == ADDR_W'(i))),
      .cnt       (cnt[i]),
      .busy      (busyBits[i]),
      .underflow (underflowBits[i])
    );
  end

  assign busy_vec = {busyBits, 1'b0};

  // Any counter underflow latches err until the next reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (|underflowBits) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard
// Directed self-checking bench for reg_scoreboard with hand-computed
// expected values for ready, busy_vec and err.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_dst;
  logic        issue_wr;
  logic [4:0]  issue_rs;
  logic [4:0]  issue_rt;
  logic        issue_uses_rs;
  logic        issue_uses_rt;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] busy_vec;
  logic        err;

  int errors = 0;
  int checks = 0;

  reg_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_dst     (issue_dst),
    .issue_wr      (issue_wr),
    .issue_rs      (issue_rs),
    .issue_rt      (issue_rt),
    .issue_uses_rs (issue_uses_rs),
    .issue_uses_rt (issue_uses_rt),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_dst        (wb_dst),
    .busy_vec      (busy_vec),
    .err           (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives every DUT input, then lets combinational logic settle.
  task automatic applyStimulus(input logic v, input logic wr, input logic [4:0] dst,
                               input logic urs, input logic [4:0] rs,
                               input logic urt, input logic [4:0] rt,
                               input logic wbv, input logic [4:0] wbd);
    issue_valid   = v;
    issue_wr      = wr;
    issue_dst     = dst;
    issue_uses_rs = urs;
    issue_rs      = rs;
    issue_uses_rt = urt;
    issue_rt      = rt;
    wb_valid      = wbv;
    wb_dst        = wbd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    checkOutput("reset_ready", 32'(issue_ready), 32'd1);
    checkOutput("reset_busy", busy_vec, 32'h0);
    checkOutput("reset_err", 32'(err), 32'd0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Issue dst=5, then a reader of r5 stalls until the cycle after wb.
    applyStimulus(1, 1, 5'd5, 0, 0, 0, 0, 0, 0);
    checkOutput("dst5_ready", 32'(issue_ready), 32'd1);
    tick();
    checkOutput("dst5_busy", busy_vec, 32'h0000_0020);
    applyStimulus(1, 0, 0, 1, 5'd5, 0, 0, 0, 0);
    checkOutput("rs5_stall", 32'(issue_ready), 32'd0);
    tick();
    applyStimulus(1, 0, 0, 1, 5'd5, 0, 0, 1, 5'd5);
    checkOutput("rs5_nobypass", 32'(issue_ready), 32'd0);
    tick();
    applyStimulus(1, 0, 0, 1, 5'd5, 0, 0, 0, 0);
    checkOutput("rs5_released", 32'(issue_ready), 32'd1);
    checkOutput("rs5_busy", busy_vec, 32'h0);
    tick();

    // Register 0 never becomes busy and a retire to it is harmless.
    applyStimulus(1, 1, 5'd0, 0, 0, 0, 0, 0, 0);
    checkOutput("dst0_ready", 32'(issue_ready), 32'd1);
    tick();
    checkOutput("dst0_busy", busy_vec, 32'h0);
    applyStimulus(1, 0, 0, 1, 5'd0, 1, 5'd0, 1, 5'd0);
    checkOutput("rs0_ready", 32'(issue_ready), 32'd1);
    tick();
    checkOutput("wb0_err", 32'(err), 32'd0);

    // Three writes to r7 fill its counter; a fourth write stalls.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
      tick();
    end
    checkOutput("dst7_busy", busy_vec, 32'h0000_0080);
    applyStimulus(1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    checkOutput("dst7_full", 32'(issue_ready), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 5'd7, 0, 0);
    checkOutput("rt7_unused", 32'(issue_ready), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 5'd7, 0, 0);
    checkOutput("rt7_stall", 32'(issue_ready), 32'd0);
    applyStimulus(1, 1, 5'd7, 0, 0, 0, 0, 1, 5'd7);
    checkOutput("dst7_full_wb", 32'(issue_ready), 32'd0);
    tick();
    applyStimulus(1, 1, 5'd7, 0, 0, 0, 0, 0, 0);
    checkOutput("dst7_room", 32'(issue_ready), 32'd1);
    checkOutput("dst7_still_busy", busy_vec, 32'h0000_0080);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd7);
    tick();
    tick();
    checkOutput("dst7_drained", busy_vec, 32'h0);
    checkOutput("dst7_err", 32'(err), 32'd0);

    // Same-cycle issue and retire on r9 leaves its count at one.
    applyStimulus(1, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 5'd9, 0, 0, 0, 0, 1, 5'd9);
    tick();
    checkOutput("r9_same_busy", busy_vec, 32'h0000_0200);
    checkOutput("r9_same_err", 32'(err), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
    tick();
    checkOutput("r9_one_left", busy_vec, 32'h0);
    checkOutput("r9_no_under", 32'(err), 32'd0);

    // Retire to idle r12 sets err, which then sticks.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd12);
    tick();
    checkOutput("r12_err", 32'(err), 32'd1);
    checkOutput("r12_busy", busy_vec, 32'h0);
    applyStimulus(1, 1, 5'd8, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 5'd9, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 5'd10, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 5'd11, 0, 0, 0, 0, 1, 5'd8);
    tick();
    checkOutput("indep_busy", busy_vec, 32'h0000_0E00);
    applyStimulus(1, 1, 5'd8, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("f00_busy", busy_vec, 32'h0000_0F00);
    checkOutput("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset mid-cycle clears everything before the next edge.
    applyStimulus(1, 0, 0, 1, 5'd8, 1, 5'd11, 0, 0);
    checkOutput("pre_rst_ready", 32'(issue_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_busy", busy_vec, 32'h0);
    checkOutput("async_err", 32'(err), 32'd0);
    checkOutput("async_ready", 32'(issue_ready), 32'd1);
    idle();
    tick();
    #2 rst_n = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 5'd8);
    tick();
    checkOutput("post_rst_wb_err", 32'(err), 32'd1);
    checkOutput("post_rst_busy", busy_vec, 32'h0);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
